// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
//
// Exhaustively exercises a 3-input combinational device under test. On an
// accepted start it latches the expected truth table, then walks the stimulus
// {a,b,c} through 000..111. Each vector is held for SETTLE_CYCLES clocks. The
// DUT response is sampled on the last edge of that window and compared with
// the latched expectation. Mismatches are recorded per vector in fail_map_o,
// and err_count_o gives their total.
//
// Parameters
//   SETTLE_CYCLES  clocks each vector is held before sampling (legal 1..15)
//
// Ports
//   clk_i          system clock, rising-edge active
//   reset_i        asynchronous active-high reset
//   start_i        run request, honoured only when idle or done
//   expected_i     expected table, bit k is the response to vector k={a,b,c}
//   dut_y_i        response of the device under test (synchronous to clk_i)
//   a_o/b_o/c_o    stimulus bits (a_o is the MSB of the vector index)
//   busy_o         high while vectors are being applied
//   done_o         high from the end of a run until the next accepted start
//   pass_o         done_o with no mismatches
//   err_count_o    number of mismatching vectors in the last run (0..8)
//   fail_map_o     per-vector mismatch flags of the last run
// -----------------------------------------------------------------------------
module truth_table_checker #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] expected_i,
  input  logic       dut_y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] err_count_o,
  output logic [7:0] fail_map_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Settle-counter value at which the response is sampled.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  // Population count of an 8-bit map. err_count is always derived from the
  // failure map with this function, so the two can never disagree.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  state_e     state_q,  state_d;
  logic [2:0] idx_q,    idx_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] exp_q,    exp_d;
  logic [7:0] fail_q,   fail_d;
  logic [3:0] err_q,    err_d;
  logic [2:0] abc_q,    abc_d;
  logic       busy_q,   busy_d;
  logic       done_q,   done_d;
  logic       pass_q,   pass_d;
  logic       mismatch_s;

  // Next-state and next-output logic for the whole checker.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    exp_d      = exp_q;
    fail_d     = fail_q;
    abc_d      = abc_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    mismatch_s = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          // Accepted start: latch the table, clear last run's results.
          exp_d    = expected_i;
          fail_d   = 8'd0;
          idx_d    = 3'd0;
          settle_d = 4'd0;
          abc_d    = 3'd0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          state_d  = ST_RUN;
        end else begin
          state_d  = state_q;
        end
      end

      ST_RUN: begin
        // start_i and expected_i are deliberately not looked at here.
        if (settle_q == SETTLE_LAST) begin
          mismatch_s = (dut_y_i != exp_q[idx_q]);
          if (mismatch_s) begin
            fail_d = fail_q | (8'd1 << idx_q);
          end else begin
            fail_d = fail_q;
          end
          settle_d = 4'd0;
          if (idx_q == 3'd7) begin
            // Eighth sample taken: stop without wrapping the index.
            state_d = ST_DONE;
            idx_d   = 3'd0;
            abc_d   = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (popcount8(fail_d) == 4'd0);
          end else begin
            idx_d   = idx_q + 3'd1;
            abc_d   = idx_q + 3'd1;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a clean idle state.
        state_d  = ST_IDLE;
        idx_d    = 3'd0;
        settle_d = 4'd0;
        fail_d   = 8'd0;
        abc_d    = 3'd0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        pass_d   = 1'b0;
      end
    endcase

    err_d = popcount8(fail_d);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      settle_q <= 4'd0;
      exp_q    <= 8'd0;
      fail_q   <= 8'd0;
      err_q    <= 4'd0;
      abc_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      abc_q    <= abc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign a_o         = abc_q[2];
  assign b_o         = abc_q[1];
  assign c_o         = abc_q[0];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_map_o  = fail_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  localparam int SC4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start4, start1;
  logic [7:0] exp4, exp1;
  logic [7:0] resp4, resp1;   // response table of the emulated device
  logic       a4, b4, c4, busy4, done4, pass4;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] err4, err1;
  logic [7:0] fail4, fail1;
  logic       y4, y1;

  assign y4 = resp4[{a4, b4, c4}];
  assign y1 = resp1[{a1, b1, c1}];

  truth_table_checker #(.SETTLE_CYCLES(SC4)) dut4 (
    .clk_i(clk), .reset_i(reset), .start_i(start4), .expected_i(exp4),
    .dut_y_i(y4), .a_o(a4), .b_o(b4), .c_o(c4), .busy_o(busy4),
    .done_o(done4), .pass_o(pass4), .err_count_o(err4), .fail_map_o(fail4));

  truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .expected_i(exp1),
    .dut_y_i(y1), .a_o(a1), .b_o(b1), .c_o(c1), .busy_o(busy1),
    .done_o(done1), .pass_o(pass1), .err_count_o(err1), .fail_map_o(fail1));

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Majority-of-three truth table, built from the vector's bit count.
  function automatic logic [7:0] majority_table();
    logic [7:0] t;
    for (int k = 0; k < 8; k++) begin
      t[k] = ((k & 1) + ((k >> 1) & 1) + ((k >> 2) & 1)) >= 2;
    end
    return t;
  endfunction

  // One full run on the SETTLE_CYCLES=4 instance. Reference: vector k is
  // shown for SC4 cycles in order; a vector fails when the device's response
  // differs from the expected bit; the result shows 8*SC4 edges after start.
  task automatic run4(input logic [7:0] e, input logic [7:0] r, input bit repulse, input string tag);
    logic [7:0] want_fail;
    int         want_err;
    want_fail = 8'd0;
    want_err  = 0;
    for (int k = 0; k < 8; k++) begin
      if (r[k] != e[k]) begin
        want_fail[k] = 1'b1;
        want_err++;
      end
    end
    exp4  = e;
    resp4 = r;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < SC4; j++) begin
        @(negedge clk);
        check({tag, "_abc"}, {29'd0, a4, b4, c4}, k);
        check({tag, "_busy"}, {31'd0, busy4}, 1);
        check({tag, "_done_low"}, {31'd0, done4}, 0);
        if (k == 0 && j == 0) begin
          check({tag, "_cleared_err"}, {28'd0, err4}, 0);
          check({tag, "_cleared_map"}, {24'd0, fail4}, 0);
        end
        if (repulse && k == 3 && j == 0) begin
          start4 = 1'b1;
          exp4   = ~e;
        end else if (repulse && k == 3 && j == 1) begin
          start4 = 1'b0;
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    check({tag, "_done"}, {31'd0, done4}, 1);
    check({tag, "_busy_end"}, {31'd0, busy4}, 0);
    check({tag, "_abc_end"}, {29'd0, a4, b4, c4}, 0);
    check({tag, "_err"}, {28'd0, err4}, want_err);
    check({tag, "_map"}, {24'd0, fail4}, want_fail);
    check({tag, "_pass"}, {31'd0, pass4}, (want_err == 0) ? 1 : 0);
  endtask

  initial begin
    logic [7:0] maj;
    logic [7:0] re, rr;
    maj    = majority_table();
    reset  = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    exp4   = 8'd0;
    exp1   = 8'd0;
    resp4  = 8'd0;
    resp1  = 8'd0;

    #1;
    check("rst_busy", {31'd0, busy4}, 0);
    check("rst_done", {31'd0, done4}, 0);
    check("rst_pass", {31'd0, pass4}, 0);
    check("rst_err", {28'd0, err4}, 0);
    check("rst_map", {24'd0, fail4}, 0);
    check("rst_abc", {29'd0, a4, b4, c4}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", {31'd0, busy4}, 0);

    run4(8'hE8, maj, 1'b0, "maj_ok");
    run4(8'h96, maj, 1'b0, "maj_96");
    run4(8'hFF, 8'h00, 1'b0, "zero_ff");
    // Results of the previous run stay put while done.
    repeat (5) @(negedge clk);
    check("hold_err", {28'd0, err4}, 8);
    check("hold_map", {24'd0, fail4}, 8'hFF);
    check("hold_done", {31'd0, done4}, 1);
    run4(8'h00, 8'h00, 1'b0, "zero_00");
    run4(8'hE8, maj, 1'b1, "repulse");

    for (int n = 0; n < 3; n++) begin
      re = 8'($urandom);
      rr = 8'($urandom);
      run4(re, rr, 1'b0, "rand");
    end

    // Reset in the middle of vector 011.
    exp4  = 8'hE8;
    resp4 = maj;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (3 * SC4 + 1) @(posedge clk);
    #2;
    check("pre_rst_abc", {29'd0, a4, b4, c4}, 3);
    reset = 1'b1;
    #1;
    check("mid_rst_abc", {29'd0, a4, b4, c4}, 0);
    check("mid_rst_busy", {31'd0, busy4}, 0);
    check("mid_rst_done", {31'd0, done4}, 0);
    check("mid_rst_pass", {31'd0, pass4}, 0);
    check("mid_rst_err", {28'd0, err4}, 0);
    check("mid_rst_map", {24'd0, fail4}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_idle", {29'd0, busy4, done4, (a4 | b4 | c4)}, 0);
    end

    // SETTLE_CYCLES=1 instance with start held high across two runs.
    exp1  = 8'hE8;
    resp1 = maj;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("s1_abc", {29'd0, a1, b1, c1}, k);
      check("s1_busy", {31'd0, busy1}, 1);
      @(posedge clk);
    end
    @(negedge clk);
    check("s1_done", {31'd0, done1}, 1);
    check("s1_pass", {31'd0, pass1}, 1);
    check("s1_busy_end", {31'd0, busy1}, 0);
    @(negedge clk);
    check("s1_done_drop", {31'd0, done1}, 0);
    check("s1_restart_busy", {31'd0, busy1}, 1);
    check("s1_restart_abc", {29'd0, a1, b1, c1}, 0);
    start1 = 1'b0;
    @(negedge clk);
    check("s1_restart_abc1", {29'd0, a1, b1, c1}, 1);
    repeat (7) @(negedge clk);
    check("s1_done2", {31'd0, done1}, 1);
    check("s1_map2", {24'd0, fail1}, 0);
    @(negedge clk);
    check("s1_done2_hold", {31'd0, done1}, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
